// File: rtl/cliff_pkg.sv
// Shared types for the LED cliff game: FSM state and steering direction
// encodings plus an index-width helper.
package cliff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_STOP = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cliff_engine_if.sv
// Button pulses, cliff sizes and display/status outputs of the cliff game.
// Every input is sampled on the clk edge and needs no handshake.
interface cliff_engine_if #(
    parameter int N_LEDS  = 16,
    parameter int CLIFF_W = 3,
    parameter int SCORE_W = 16
);
    localparam int POS_W = cliff_pkg::idx_w(N_LEDS);

    logic               start;
    logic               left;
    logic               right;
    logic               speed_up;
    logic               speed_down;
    logic [CLIFF_W-1:0] lcliff;
    logic [CLIFF_W-1:0] rcliff;
    logic [N_LEDS-1:0]  led;
    logic [POS_W-1:0]   pos;
    logic [1:0]         state;
    logic [1:0]         speed;
    logic               lose;
    logic [SCORE_W-1:0] score;
    logic               tick;

    modport master (
        output start, left, right, speed_up, speed_down, lcliff, rcliff,
        input  led, pos, state, speed, lose, score, tick
    );

    modport slave (
        input  start, left, right, speed_up, speed_down, lcliff, rcliff,
        output led, pos, state, speed, lose, score, tick
    );

endinterface

// File: rtl/cliff_tick_gen.sv
// Programmable-period strobe divider: one-cycle tick every period_i clocks,
// a new period is picked up only when the counter reloads.
module cliff_tick_gen #(
    parameter int               CNT_W      = 26,
    parameter logic [CNT_W-1:0] RESET_LOAD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q - 1'b1;
        tick_d = 1'b0;
        if (cnt_q == '0) begin
            cnt_d  = period_i - 1'b1;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= RESET_LOAD;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/cliff_engine.sv
// LED cliff game core: group movement, tick-paced stepping, cliff-fall detection
// and survival score. Optional macro CLIFF_BLINK_EN blinks the group while LOST.
module cliff_engine
    import cliff_pkg::*;
#(
    parameter int N_LEDS    = 16,
    parameter int GROUP_W   = 3,
    parameter int START_POS = 6,
    parameter int CLIFF_W   = 3,
    parameter int MAX_SPEED = 2,
    parameter int PERIOD0   = 50000000,
    parameter int PERIOD1   = 12500000,
    parameter int PERIOD2   = 5000000,
    parameter int PERIOD3   = 2500000,
    parameter int SCORE_W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    cliff_engine_if.slave  bus
);
    localparam int POS_W = idx_w(N_LEDS);
    localparam int PM01  = (PERIOD0 > PERIOD1) ? PERIOD0 : PERIOD1;
    localparam int PM23  = (PERIOD2 > PERIOD3) ? PERIOD2 : PERIOD3;
    localparam int PMAX  = (PM01 > PM23) ? PM01 : PM23;
    localparam int CNT_W = idx_w(PMAX + 1);

    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(N_LEDS - GROUP_W);
    localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);
    localparam logic [1:0]       SPD_MAX   = 2'(MAX_SPEED);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [1:0]         speed_q, speed_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [N_LEDS-1:0]  led_q, led_d;
    logic [N_LEDS-1:0]  cliff_mask, grp_mask, start_mask;
    logic [CNT_W-1:0]   period;
    logic               overlap;
    logic               tick;
    logic               show_grp;

    always_comb begin
        case (speed_q)
            2'd0:    period = CNT_W'(PERIOD0);
            2'd1:    period = CNT_W'(PERIOD1);
            2'd2:    period = CNT_W'(PERIOD2);
            default: period = CNT_W'(PERIOD3);
        endcase
    end

    cliff_tick_gen #(
        .CNT_W      (CNT_W),
        .RESET_LOAD (CNT_W'(PERIOD0 - 1))
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .period_i (period),
        .tick_o   (tick)
    );

    // Overlapping cliffs need no special case: every bit satisfies one test.
    always_comb begin
        cliff_mask = '0;
        grp_mask   = '0;
        start_mask = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            cliff_mask[i] = (i >= N_LEDS - 1 - int'(bus.lcliff)) || (i <= int'(bus.rcliff));
            grp_mask[i]   = (i >= int'(pos_q)) && (i < int'(pos_q) + GROUP_W);
            start_mask[i] = (i >= START_POS) && (i < START_POS + GROUP_W);
        end
    end

    assign overlap = |(grp_mask & cliff_mask);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state; start outranks a detected fall
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.start)    state_d = ST_IDLE;
                else if (overlap) state_d = ST_LOST;
            end
            ST_LOST: if (bus.start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.state = state_q;
        bus.lose  = (state_q == ST_LOST);
    end

    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        score_d = score_q;
        if (state_q != ST_LOST) begin
            if (bus.speed_up) begin
                if (speed_q < SPD_MAX) speed_d = speed_q + 2'd1;
            end else if (bus.speed_down) begin
                if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    score_d = '0;
                    dir_d   = DIR_STOP;
                end else if (bus.left) begin
                    if (pos_q < POS_MAX) pos_d = pos_q + 1'b1;
                end else if (bus.right) begin
                    if (pos_q != '0) pos_d = pos_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.start) begin
                    pos_d   = POS_START;
                    speed_d = 2'd0;
                    dir_d   = DIR_STOP;
                end else begin
                    if (bus.left)       dir_d = DIR_UP;
                    else if (bus.right) dir_d = DIR_DN;
                    // The step uses the direction held before this cycle's steer pulse.
                    if (tick) begin
                        if (dir_q == DIR_UP && pos_q < POS_MAX) pos_d = pos_q + 1'b1;
                        if (dir_q == DIR_DN && pos_q != '0)     pos_d = pos_q - 1'b1;
                        if (score_q != '1) score_d = score_q + 1'b1;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    pos_d   = POS_START;
                    speed_d = 2'd0;
                    dir_d   = DIR_STOP;
                end
            end
        endcase
    end

`ifdef CLIFF_BLINK_EN
    logic blink_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != ST_LOST) blink_q <= 1'b0;
        else if (tick)                   blink_q <= ~blink_q;
    end

    assign show_grp = !((state_q == ST_LOST) && blink_q);
`else
    assign show_grp = 1'b1;
`endif

    assign led_d = cliff_mask | (show_grp ? grp_mask : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= POS_START;
            dir_q   <= DIR_STOP;
            speed_q <= 2'd0;
            score_q <= '0;
            led_q   <= start_mask | cliff_mask;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            score_q <= score_d;
            led_q   <= led_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.pos   = pos_q;
    assign bus.speed = speed_q;
    assign bus.score = score_q;
    assign bus.tick  = tick;

endmodule

// File: tb/tb_cliff_engine.sv
// Directed bench for cliff_engine: IDLE vector table plus hand-written RUN/LOST
// sequences, with PERIOD0..3 shortened to 8/4/2/1.
module tb_cliff_engine;
    import cliff_pkg::*;

    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_START = 5'b10000;
    localparam logic [4:0] P_LEFT  = 5'b01000;
    localparam logic [4:0] P_RIGHT = 5'b00100;
    localparam logic [4:0] P_UP    = 5'b00010;
    localparam logic [4:0] P_DN    = 5'b00001;

    typedef struct {
        logic [4:0]  p;
        logic [2:0]  lc;
        logic [2:0]  rc;
        logic [3:0]  pos;
        logic [1:0]  spd;
        logic [15:0] led;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[13];

    always #5 clk = ~clk;

    cliff_engine_if #(.N_LEDS(16), .CLIFF_W(3), .SCORE_W(16)) bus ();

    cliff_engine #(
        .N_LEDS(16), .GROUP_W(3), .START_POS(6), .CLIFF_W(3), .MAX_SPEED(2),
        .PERIOD0(8), .PERIOD1(4), .PERIOD2(2), .PERIOD3(1), .SCORE_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Called at a negedge; holds the pulse for one posedge, returns at the next negedge.
    task automatic drive(input logic [4:0] p);
        {bus.start, bus.left, bus.right, bus.speed_up, bus.speed_down} = p;
        @(posedge clk);
        @(negedge clk);
        {bus.start, bus.left, bus.right, bus.speed_up, bus.speed_down} = P_NONE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n++;
            if (bus.tick === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic wait_state(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.state === s) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;

        vt[0]  = '{P_LEFT,         3'd0, 3'd0, 4'd7,  2'd0, 16'h8381};
        vt[1]  = '{P_LEFT,         3'd0, 3'd0, 4'd8,  2'd0, 16'h8701};
        vt[2]  = '{P_LEFT,         3'd0, 3'd0, 4'd9,  2'd0, 16'h8E01};
        vt[3]  = '{P_LEFT|P_RIGHT, 3'd0, 3'd0, 4'd10, 2'd0, 16'h9C01};
        vt[4]  = '{P_RIGHT,        3'd0, 3'd0, 4'd9,  2'd0, 16'h8E01};
        vt[5]  = '{P_UP,           3'd0, 3'd0, 4'd9,  2'd1, 16'h8E01};
        vt[6]  = '{P_UP|P_DN,      3'd0, 3'd0, 4'd9,  2'd2, 16'h8E01};
        vt[7]  = '{P_UP,           3'd0, 3'd0, 4'd9,  2'd2, 16'h8E01};
        vt[8]  = '{P_DN,           3'd0, 3'd0, 4'd9,  2'd1, 16'h8E01};
        vt[9]  = '{P_DN,           3'd0, 3'd0, 4'd9,  2'd0, 16'h8E01};
        vt[10] = '{P_DN,           3'd0, 3'd0, 4'd9,  2'd0, 16'h8E01};
        vt[11] = '{P_NONE,         3'd7, 3'd7, 4'd9,  2'd0, 16'hFFFF};
        vt[12] = '{P_NONE,         3'd0, 3'd2, 4'd9,  2'd0, 16'h8E07};

        {bus.start, bus.left, bus.right, bus.speed_up, bus.speed_down} = P_NONE;
        bus.lcliff = 3'd0;
        bus.rcliff = 3'd0;
        do_reset();

        check("rst_led",   bus.led,   16'h81C1);
        check("rst_pos",   bus.pos,   4'd6);
        check("rst_state", bus.state, 2'd0);
        check("rst_speed", bus.speed, 2'd0);
        check("rst_score", bus.score, 16'd0);
        check("rst_lose",  bus.lose,  1'b0);
        check("rst_tick",  bus.tick,  1'b0);

        for (int i = 0; i < 13; i++) begin
            bus.lcliff = vt[i].lc;
            bus.rcliff = vt[i].rc;
            drive(vt[i].p);
            @(negedge clk);
            check($sformatf("vec%0d_pos", i),   bus.pos,   vt[i].pos);
            check($sformatf("vec%0d_state", i), bus.state, 2'd0);
            check($sformatf("vec%0d_speed", i), bus.speed, vt[i].spd);
            check($sformatf("vec%0d_led", i),   bus.led,   vt[i].led);
        end

        // IDLE right clamp, no loss although the group sits on the low cliff
        bus.rcliff = 3'd0;
        repeat (15) drive(P_RIGHT);
        @(negedge clk);
        check("idle_clamp_pos", bus.pos,   4'd0);
        check("idle_state",     bus.state, 2'd0);
        check("idle_lose",      bus.lose,  1'b0);
        check("idle_led",       bus.led,   16'h8007);

        // RUN upward at speed 0 into the high cliff
        do_reset();
        drive(P_START);
        check("run_state", bus.state, 2'd1);
        drive(P_LEFT);
        wait_tick(n);
        wait_tick(n);
        check("tick_period8", n, 8);
        check("run_pos7",     bus.pos,   4'd7);
        check("run_score1",   bus.score, 16'd1);
        wait_state(2'd2, ok);
        check("reach_lost",  ok,        1'b1);
        check("lost_pos",    bus.pos,   4'd13);
        check("lost_score",  bus.score, 16'd7);
        check("lost_lose",   bus.lose,  1'b1);
        repeat (20) @(negedge clk);
        check("lost_pos_frozen",   bus.pos,   4'd13);
        check("lost_score_frozen", bus.score, 16'd7);
        drive(P_RIGHT);
        drive(P_UP);
        check("lost_ignore_pos",   bus.pos,   4'd13);
        check("lost_ignore_speed", bus.speed, 2'd0);
        check("lost_ignore_state", bus.state, 2'd2);
        drive(P_START);
        check("restart_state", bus.state, 2'd0);
        check("restart_pos",   bus.pos,   4'd6);
        check("restart_speed", bus.speed, 2'd0);
        check("restart_score", bus.score, 16'd7);
        check("restart_lose",  bus.lose,  1'b0);

        // RUN speed changes
        drive(P_START);
        check("run2_score0", bus.score, 16'd0);
        repeat (5) drive(P_UP);
        check("speed_sat", bus.speed, 2'd2);
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("tick_period2", n, 2);
        drive(P_DN);
        check("speed_dn", bus.speed, 2'd1);
        drive(P_UP | P_DN);
        check("speed_up_wins", bus.speed, 2'd2);
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        check("tick_period2b", n, 2);

        // Live low cliff, then one step down into it
        bus.rcliff = 3'd5;
        repeat (6) @(negedge clk);
        check("rcliff_no_loss", bus.state, 2'd1);
        check("rcliff_pos",     bus.pos,   4'd6);
        drive(P_RIGHT);
        wait_state(2'd2, ok);
        check("reach_lost2", ok,      1'b1);
        check("lost2_pos",   bus.pos, 4'd5);
        repeat (4) @(negedge clk);
        check("lost2_led", bus.led, 16'h80FF);

        // Start position already inside a cliff: LOST one cycle after RUN
        drive(P_START);
        check("idle3_state", bus.state, 2'd0);
        check("idle3_pos",   bus.pos,   4'd6);
        bus.rcliff = 3'd6;
        drive(P_START);
        check("inside_run",  bus.state, 2'd1);
        @(negedge clk);
        check("inside_lost", bus.state, 2'd2);
        drive(P_START);
        bus.rcliff = 3'd0;

        // Reset asserted mid-RUN
        drive(P_START);
        drive(P_LEFT);
        drive(P_UP);
        wait_tick(n);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_state", bus.state, 2'd0);
        check("mid_rst_pos",   bus.pos,   4'd6);
        check("mid_rst_speed", bus.speed, 2'd0);
        check("mid_rst_score", bus.score, 16'd0);
        check("mid_rst_lose",  bus.lose,  1'b0);
        check("mid_rst_tick",  bus.tick,  1'b0);
        check("mid_rst_led",   bus.led,   16'h81C1);
        wait_tick(n);
        check("rst_first_tick", n, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
